// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU control and its multiply/divide unit:
// funct field values, ALU op codes and the multiply/divide state/kind encodings.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_NOP   = 2'b11;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // The HI/LO group; funct[1] selects divide and funct[0] selects unsigned for the md ops.
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    typedef enum logic {MD_IDLE, MD_RUN} md_state_e;
    typedef enum logic {MD_MUL, MD_DIV} md_kind_e;

    function automatic logic isMdFunct(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/alu_control_md_if.sv
// Bundle of the EX-stage instruction inputs and ALU-control/HI-LO outputs.
// The pipeline side is the master, the ALU control block is the slave.
interface alu_control_md_if #(parameter int DATA_W = 32);

    logic              ex_valid;
    logic              flush;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [3:0]        post_alu_op;
    logic              stall;
    logic              mf_valid;
    logic [DATA_W-1:0] mf_data;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              md_busy;

    modport master (
        output ex_valid, flush, alu_op, funct, rs_val, rt_val,
        input  post_alu_op, stall, mf_valid, mf_data, hi_q, lo_q, md_busy
    );

    modport slave (
        input  ex_valid, flush, alu_op, funct, rs_val, rt_val,
        output post_alu_op, stall, mf_valid, mf_data, hi_q, lo_q, md_busy
    );

endinterface

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide on operand magnitudes: one shift-add or restoring
// shift-subtract step per clock, with the sign fix-up applied to the final step's result.
module md_iter_unit
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_is_div,
    input  logic              i_is_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    md_state_e         r_state;
    md_state_e         w_nextState;
    md_kind_e          r_kind;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mq;
    logic [DATA_W-1:0] r_opnd;
    logic [DATA_W-1:0] r_rawA;
    logic              r_negMain;
    logic              r_negRem;
    logic              r_divZero;

    logic [DATA_W-1:0]   w_aMag;
    logic [DATA_W-1:0]   w_bMag;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_shifted;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_nextAcc;
    logic [DATA_W-1:0]   w_nextMq;
    logic [2*DATA_W-1:0] w_prodMag;
    logic [2*DATA_W-1:0] w_prod;

    assign w_aMag = (i_is_signed && i_a[DATA_W-1]) ? -i_a : i_a;
    assign w_bMag = (i_is_signed && i_b[DATA_W-1]) ? -i_b : i_b;

    assign o_busy = (r_state == MD_RUN);
    assign o_done = o_busy && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            MD_IDLE: if (i_start) w_nextState = MD_RUN;
            MD_RUN:  if (r_cnt == '0) w_nextState = MD_IDLE;
            default: w_nextState = MD_IDLE;
        endcase
    end

    // Multiply keeps {acc, mq} as the partial product; divide keeps acc as the
    // partial remainder and shifts quotient bits into mq as the dividend shifts out.
    always_comb begin
        w_sum     = {1'b0, r_acc} + {1'b0, r_opnd};
        w_shifted = {r_acc, r_mq[DATA_W-1]};
        w_diff    = w_shifted - {1'b0, r_opnd};
        w_nextAcc = r_acc;
        w_nextMq  = r_mq;
        if (r_kind == MD_MUL) begin
            if (r_mq[0]) begin
                {w_nextAcc, w_nextMq} = {w_sum, r_mq[DATA_W-1:1]};
            end else begin
                {w_nextAcc, w_nextMq} = {1'b0, r_acc, r_mq[DATA_W-1:1]};
            end
        end else begin
            if (!w_diff[DATA_W]) begin
                w_nextAcc = w_diff[DATA_W-1:0];
                w_nextMq  = {r_mq[DATA_W-2:0], 1'b1};
            end else begin
                w_nextAcc = w_shifted[DATA_W-1:0];
                w_nextMq  = {r_mq[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign w_prodMag = {w_nextAcc, w_nextMq};
    assign w_prod    = r_negMain ? -w_prodMag : w_prodMag;

    always_comb begin
        o_hi = w_prod[2*DATA_W-1:DATA_W];
        o_lo = w_prod[DATA_W-1:0];
        if (r_kind == MD_DIV) begin
            if (r_divZero) begin
                o_hi = r_rawA;
                o_lo = '1;
            end else begin
                o_hi = r_negRem  ? -w_nextAcc : w_nextAcc;
                o_lo = r_negMain ? -w_nextMq  : w_nextMq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind    <= MD_MUL;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_opnd    <= '0;
            r_rawA    <= '0;
            r_negMain <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
        end else if ((r_state == MD_IDLE) && i_start) begin
            r_kind    <= i_is_div ? MD_DIV : MD_MUL;
            r_cnt     <= CNT_W'(DATA_W - 1);
            r_acc     <= '0;
            r_mq      <= i_is_div ? w_aMag : w_bMag;
            r_opnd    <= i_is_div ? w_bMag : w_aMag;
            r_rawA    <= i_a;
            r_negMain <= i_is_signed && (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
            r_negRem  <= i_is_signed && i_a[DATA_W-1];
            r_divZero <= i_is_div && (i_b == '0);
        end else if (r_state == MD_RUN) begin
            r_acc <= w_nextAcc;
            r_mq  <= w_nextMq;
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU control: funct decode, HI/LO interlock and the HI/LO registers
// fed by the iterative multiply/divide unit.
module alu_control_md
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input logic            clk,
    input logic            rst_n,
    alu_control_md_if.slave bus
);

    logic [3:0]        w_aluOp;
    logic              w_isRType;
    logic              w_isMd;
    logic              w_isMf;
    logic              w_isMt;
    logic              w_stall;
    logic              w_accept;
    logic              w_busy;
    logic              w_done;
    logic [DATA_W-1:0] w_mdHi;
    logic [DATA_W-1:0] w_mdLo;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    always_comb begin
        w_aluOp = ALU_NOP;
        case (bus.alu_op)
            ALUOP_ADD: w_aluOp = ALU_ADD;
            ALUOP_SUB: w_aluOp = ALU_SUB;
            ALUOP_RTYPE: begin
                case (bus.funct)
                    FN_ADD, FN_ADDU: w_aluOp = ALU_ADD;
                    FN_SUB, FN_SUBU: w_aluOp = ALU_SUB;
                    FN_AND:          w_aluOp = ALU_AND;
                    FN_OR:           w_aluOp = ALU_OR;
                    FN_XOR:          w_aluOp = ALU_XOR;
                    FN_NOR:          w_aluOp = ALU_NOR;
                    FN_SLT:          w_aluOp = ALU_SLT;
                    FN_SLTU:         w_aluOp = ALU_SLTU;
                    default:         w_aluOp = ALU_NOP;
                endcase
            end
            default: w_aluOp = ALU_NOP;
        endcase
    end

    assign w_isRType = (bus.alu_op == ALUOP_RTYPE);
    assign w_isMd    = w_isRType && isMdFunct(bus.funct);
    assign w_isMf    = w_isRType && ((bus.funct == FN_MFHI) || (bus.funct == FN_MFLO));
    assign w_isMt    = w_isRType && ((bus.funct == FN_MTHI) || (bus.funct == FN_MTLO));

    // Any HI/LO-group op must wait while the unit runs; flush only blocks acceptance.
    assign w_stall  = bus.ex_valid && (w_isMd || w_isMf || w_isMt) && w_busy;
    assign w_accept = bus.ex_valid && !bus.flush && !w_stall;

    md_iter_unit #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_md (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_accept && w_isMd),
        .i_is_div    (bus.funct[1]),
        .i_is_signed (!bus.funct[0]),
        .i_a         (bus.rs_val),
        .i_b         (bus.rt_val),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_hi        (w_mdHi),
        .o_lo        (w_mdLo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= w_mdHi;
            r_lo <= w_mdLo;
        end else if (w_accept && w_isMt) begin
            if (bus.funct == FN_MTHI) r_hi <= bus.rs_val;
            else                      r_lo <= bus.rs_val;
        end
    end

    assign bus.post_alu_op = w_aluOp;
    assign bus.stall       = w_stall;
    assign bus.mf_valid    = bus.ex_valid && w_isMf && !w_stall;
    assign bus.mf_data     = (bus.funct == FN_MFHI) ? r_hi : r_lo;
    assign bus.hi_q        = r_hi;
    assign bus.lo_q        = r_lo;
    assign bus.md_busy     = w_busy;

endmodule
